// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter and address/data multiplexer that shares the single AHB
// slave port of the AHB-to-APB bridge between NUM_MASTERS AHB masters.
module ahb_bridge_arbiter #(
  parameter int  NUM_MASTERS = 4,
  parameter int  MAX_BEATS   = 4,
  parameter int  AW          = 32,
  parameter int  DW          = 32,
  localparam int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                     Hclk,
  input  logic                     Hreset,
  input  logic [NUM_MASTERS-1:0]   Hbusreq,
  input  logic [NUM_MASTERS-1:0]   Hlock,
  input  logic [2*NUM_MASTERS-1:0] Htrans_m,
  input  logic [NUM_MASTERS-1:0]   Hwrite_m,
  input  logic [AW*NUM_MASTERS-1:0] Haddr_m,
  input  logic [DW*NUM_MASTERS-1:0] Hwdata_m,
  output logic [NUM_MASTERS-1:0]   Hgrant,
  output logic [MW-1:0]            Hmaster,
  output logic                     Hmastlock,
  output logic [1:0]               Htrans,
  output logic                     Hwrite,
  output logic [AW-1:0]            Haddr,
  output logic [DW-1:0]            Hwdata,
  output logic                     Hreadyin,
  input  logic                     Hreadyout
);

  localparam logic [3:0] BEAT_MAX  = 4'(MAX_BEATS);
  localparam logic [3:0] BEAT_LAST = 4'(MAX_BEATS - 1);

  logic [NUM_MASTERS-1:0] r_grant;
  logic [MW-1:0]          r_master;
  logic [MW-1:0]          r_dmaster;
  logic [MW-1:0]          r_rr_ptr;
  logic                   r_mastlock;
  logic [3:0]             r_beats;

  logic [MW-1:0]          w_grant_idx;
  logic [NUM_MASTERS-1:0] w_owner_oh;
  logic [1:0]             w_owner_trans;
  logic                   w_owner_write;
  logic [AW-1:0]          w_owner_addr;
  logic [DW-1:0]          w_dm_wdata;
  logic [MW-1:0]          w_rr_idx;
  logic [MW-1:0]          w_new_idx;
  logic [NUM_MASTERS-1:0] w_new_oh;
  logic                   w_owner_req;
  logic                   w_owner_lock;
  logic                   w_other_req;
  logic                   w_handover_pend;
  logic                   w_beat_inc;
  logic                   w_beat_limit;
  logic                   w_arb;

  // Grant index decode plus AND-OR muxes for the address and data phases
  always_comb begin
    w_grant_idx   = '0;
    w_owner_oh    = '0;
    w_owner_trans = 2'b00;
    w_owner_write = 1'b0;
    w_owner_addr  = '0;
    w_dm_wdata    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_grant_idx   = w_grant_idx | (MW'(i) & {MW{r_grant[i]}});
      w_owner_oh[i] = (r_master == MW'(i));
      w_owner_trans = w_owner_trans | (Htrans_m[2*i +: 2] & {2{w_owner_oh[i]}});
      w_owner_write = w_owner_write | (Hwrite_m[i] & w_owner_oh[i]);
      w_owner_addr  = w_owner_addr | (Haddr_m[AW*i +: AW] & {AW{w_owner_oh[i]}});
      w_dm_wdata    = w_dm_wdata | (Hwdata_m[DW*i +: DW] & {DW{r_dmaster == MW'(i)}});
    end
  end

  // Round-robin search from the pointer+1; smallest distance wins, park on 0
  always_comb begin
    w_rr_idx = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        w_rr_idx = (Hbusreq[j] && (((int'(r_rr_ptr) + k) % NUM_MASTERS) == j)) ? MW'(j) : w_rr_idx;
      end
    end
    w_new_idx = (|Hbusreq) ? w_rr_idx : '0;
    w_new_oh  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_new_oh[i] = (w_new_idx == MW'(i));
    end
  end

  assign w_owner_req     = Hbusreq[r_master];
  assign w_owner_lock    = Hlock[r_master];
  assign w_other_req     = |(Hbusreq & ~w_owner_oh);
  // A granted master still waiting for its Hready edge is not re-arbitrated
  assign w_handover_pend = (w_grant_idx != r_master);
  assign w_beat_inc      = Hreadyout & w_owner_trans[1];
  assign w_beat_limit    = w_beat_inc & (r_beats >= BEAT_LAST);
  assign w_arb           = Hreadyout & ~w_handover_pend & ~w_owner_lock &
                           (~w_owner_req | w_beat_limit |
                            ((w_owner_trans == 2'b00) & w_other_req));

  // Grant and round-robin pointer update at arbitration points
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_grant  <= NUM_MASTERS'(1);
      r_rr_ptr <= '0;
    end else if (w_arb) begin
      r_grant  <= w_new_oh;
      r_rr_ptr <= w_new_idx;
    end
  end

  // Address/data-phase owner handover on Hready edges
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_master   <= '0;
      r_dmaster  <= '0;
      r_mastlock <= 1'b0;
    end else if (Hreadyout) begin
      r_master   <= w_grant_idx;
      r_dmaster  <= r_master;
      r_mastlock <= Hlock[w_grant_idx];
    end
  end

  // Per-tenure beat counter, cleared on re-arbitration or owner change
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_beats <= 4'd0;
    end else if (Hreadyout) begin
      if (w_arb || w_handover_pend) begin
        r_beats <= 4'd0;
      end else if (w_beat_inc && (r_beats != BEAT_MAX)) begin
        r_beats <= r_beats + 4'd1;
      end
    end
  end

  assign Hgrant    = r_grant;
  assign Hmaster   = r_master;
  assign Hmastlock = r_mastlock;
  assign Htrans    = Hreset ? 2'b00 : w_owner_trans;
  assign Hwrite    = w_owner_write;
  assign Haddr     = w_owner_addr;
  assign Hwdata    = w_dm_wdata;
  assign Hreadyin  = Hreadyout;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Scoreboard bench for ahb_bridge_arbiter: randomized stimulus, expected
// outputs from a behavioural model, compared by an independent monitor.
module tb_ahb_bridge_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic            Hclk = 1'b0;
  logic            Hreset;
  logic [N-1:0]    Hbusreq;
  logic [N-1:0]    Hlock;
  logic [2*N-1:0]  Htrans_m;
  logic [N-1:0]    Hwrite_m;
  logic [AW*N-1:0] Haddr_m;
  logic [DW*N-1:0] Hwdata_m;
  logic [N-1:0]    Hgrant;
  logic [1:0]      Hmaster;
  logic            Hmastlock;
  logic [1:0]      Htrans;
  logic            Hwrite;
  logic [AW-1:0]   Haddr;
  logic [DW-1:0]   Hwdata;
  logic            Hreadyin;
  logic            Hreadyout;

  always #5 Hclk = ~Hclk;

  ahb_bridge_arbiter #(.NUM_MASTERS(N), .MAX_BEATS(MAXB), .AW(AW), .DW(DW)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hbusreq(Hbusreq), .Hlock(Hlock),
    .Htrans_m(Htrans_m), .Hwrite_m(Hwrite_m), .Haddr_m(Haddr_m), .Hwdata_m(Hwdata_m),
    .Hgrant(Hgrant), .Hmaster(Hmaster), .Hmastlock(Hmastlock), .Htrans(Htrans),
    .Hwrite(Hwrite), .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyin(Hreadyin),
    .Hreadyout(Hreadyout)
  );

  typedef struct {
    logic [N-1:0]  grant;
    logic [1:0]    master;
    logic          mlock;
    logic [1:0]    trans;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rdyin;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Stimulus image of the current cycle
  logic [N-1:0]  s_req, s_lock;
  logic [1:0]    s_trans[N];
  logic          s_write[N];
  logic [AW-1:0] s_addr[N];
  logic [DW-1:0] s_wdata[N];
  logic          s_rdy, s_rst;

  // Reference model state: who holds the grant, who drives each phase
  int m_grant, m_owner, m_down, m_beats, m_ptr;
  bit m_mlock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_grant = 0; m_owner = 0; m_down = 0; m_beats = 0; m_ptr = 0; m_mlock = 1'b0;
  endfunction

  // Advance the model across one rising edge with the current stimulus
  function automatic void model_edge();
    int  tr, nxt;
    bit  busy, others, arb;
    if (s_rst) begin
      model_reset();
      return;
    end
    if (!s_rdy) return;
    tr     = int'(s_trans[m_owner]);
    busy   = (tr == 2) || (tr == 3);
    others = 1'b0;
    for (int j = 0; j < N; j++) if (j != m_owner && s_req[j]) others = 1'b1;
    arb = (m_grant == m_owner) && !s_lock[m_owner] &&
          (!s_req[m_owner] || (busy && (m_beats + 1 >= MAXB)) || (tr == 0 && others));
    nxt = m_grant;
    if (arb) begin
      nxt = 0;
      for (int k = N; k >= 1; k--) if (s_req[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
    end
    if (m_owner != m_grant || arb) m_beats = 0;
    else if (busy && m_beats < MAXB) m_beats = m_beats + 1;
    m_down  = m_owner;
    m_owner = m_grant;
    m_mlock = s_lock[m_grant];
    if (arb) begin
      m_grant = nxt;
      m_ptr   = nxt;
    end
  endfunction

  // One clock of stimulus: drive, record expectation, then predict the edge
  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] lock,
                       input logic [N-1:0] busy, input logic rdy, input logic rst,
                       input bit full_rand);
    exp_t e;
    @(posedge Hclk);
    #1;
    for (int i = 0; i < N; i++) begin
      s_addr[i]  = $urandom;
      s_wdata[i] = $urandom;
      s_write[i] = 1'($urandom_range(1, 0));
      if (full_rand) s_trans[i] = 2'($urandom_range(3, 0));
      else           s_trans[i] = busy[i] ? 2'($urandom_range(3, 2)) : 2'b00;
      Htrans_m[2*i +: 2]  = s_trans[i];
      Hwrite_m[i]         = s_write[i];
      Haddr_m[AW*i +: AW] = s_addr[i];
      Hwdata_m[DW*i +: DW] = s_wdata[i];
    end
    s_req = req; s_lock = lock; s_rdy = rdy; s_rst = rst;
    Hbusreq = req; Hlock = lock; Hreadyout = rdy; Hreset = rst;
    e.grant  = N'(1 << m_grant);
    e.master = 2'(m_owner);
    e.mlock  = m_mlock;
    e.trans  = rst ? 2'b00 : s_trans[m_owner];
    e.write  = s_write[m_owner];
    e.addr   = s_addr[m_owner];
    e.wdata  = s_wdata[m_down];
    e.rdyin  = rdy;
    sb_q.push_back(e);
    model_edge();
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation
  always @(negedge Hclk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("Hgrant",    32'(Hgrant),    32'(mon_e.grant));
      chk("Hmaster",   32'(Hmaster),   32'(mon_e.master));
      chk("Hmastlock", 32'(Hmastlock), 32'(mon_e.mlock));
      chk("Htrans",    32'(Htrans),    32'(mon_e.trans));
      chk("Hwrite",    32'(Hwrite),    32'(mon_e.write));
      chk("Haddr",     Haddr,          mon_e.addr);
      chk("Hwdata",    Hwdata,         mon_e.wdata);
      chk("Hreadyin",  32'(Hreadyin),  32'(mon_e.rdyin));
      chk("onehot",    32'($onehot(Hgrant)), 32'd1);
    end
  end

  initial begin
    Hreset = 1'b1; Hreadyout = 1'b1; Hbusreq = '0; Hlock = '0;
    Htrans_m = '0; Hwrite_m = '0; Haddr_m = '0; Hwdata_m = '0;
    repeat (2) @(posedge Hclk);
    model_reset();

    // Parked, no requests; then reset in the middle of a master 2 burst
    repeat (5) cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0);
    cycle(4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Master 2 alone: grant, handover, address and trailing data
    repeat (6) cycle(4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Masters 1 and 3 contend continuously
    repeat (30) cycle(4'b1010, 4'b0000, 4'b1010, 1'b1, 1'b0, 1'b0);

    // Master 1 locked against master 0, then lock released
    repeat (22) cycle(4'b0011, 4'b0010, 4'b0011, 1'b1, 1'b0, 1'b0);
    repeat (8)  cycle(4'b0011, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);

    // Handover request while the bridge stalls for 3 cycles
    repeat (3) cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    cycle(4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0);

    // Fresh reset, park, then all four request together
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (24) cycle(4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);

    // Fully random traffic with stalls, occasional locks and resets
    repeat (3000) begin
      cycle(4'($urandom),
            ($urandom_range(7, 0) == 0) ? 4'($urandom) : 4'b0000,
            4'b0000,
            1'($urandom_range(3, 0) != 0),
            1'($urandom_range(199, 0) == 0),
            1'b1);
    end

    @(negedge Hclk);
    #1;
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
